mcb_port_arbiter: RTL and testbench
===================================

// Module: mcb_port_arbiter
// PURPOSE
// - Shares one Spartan-6 MCB user port (cmd/wr/rd FIFOs) between NUM_REQ requesters.
// - Sequences each write: BL+1 data words go into the wr FIFO first, then the command is issued.
// - Routes returning read data to the requester that issued the read, in issue order.
// - Sits between the DDR test/DMA engines and the c3_pN_* ports of the MIG wrapper.
// PARAMETERS
// - NUM_REQ       2   number of requesters (1..4); requester 0 is the lowest index
// - TAG_DEPTH     4   outstanding-read tag FIFO depth (power of 2)
// PORTS
// - clk             in   1          system clock; single clock domain
// - rst             in   1          synchronous, active-high reset
// - calib_done      in   1          MCB calibration complete
// - req_valid       in   NUM_REQ    command request per requester
// - req_ready       out  NUM_REQ    command accepted (1-cycle pulse)
// - req_instr       in   3*NUM_REQ  MCB instr (0 WR, 1 RD, 2 WR_AP, 3 RD_AP, 4 REF)
// - req_bl          in   6*NUM_REQ  burst length minus 1
// - req_addr        in   30*NUM_REQ byte address
// - wdat_valid      in   NUM_REQ    write word valid
// - wdat_ready      out  NUM_REQ    write word accepted
// - wdat_data       in   32*NUM_REQ write word
// - wdat_mask       in   4*NUM_REQ  byte mask, 1 = masked
// - rdat_valid      out  NUM_REQ    read word valid for requester i
// - rdat_ready      in   NUM_REQ    requester accepts read word
// - rdat_data       out  32         shared read data bus
// - mcb_cmd_en/instr[2:0]/bl[5:0]/byte_addr[29:0]  out  command FIFO push
// - mcb_cmd_full    in   1          command FIFO full
// - mcb_wr_en/mask[3:0]/data[31:0]                 out  wr FIFO push
// - mcb_wr_full     in   1          wr FIFO full
// - mcb_rd_en       out  1          rd FIFO pop
// - mcb_rd_data     in   32         rd FIFO head
// - mcb_rd_empty    in   1          rd FIFO empty
// BEHAVIOUR
// - Reset: FSM to CALIB; all *_en, req_ready, wdat_ready, rdat_valid = 0.
// - Reset: rr pointer = 0, tag FIFO empty, word counter = 0.
// - A reset mid-burst abandons the burst; no cmd is issued for a partially written burst.
// - CALIB: wait for calib_done = 1, then go to ARB.
// - ARB: round-robin starting after the last grant; a requester is eligible only if one holds:
//   - the request is a write or REF;
//   - the request is a read and the tag FIFO is not full.
// - ARB -> WDATA for a write, -> CMD for a read or REF.
// - The request fields are latched at grant; req_ready pulses in the grant cycle.
// - WDATA: wdat_ready[g] = !mcb_wr_full. Each accepted word drives mcb_wr_en with registered data/mask.
//   - The state counts BL+1 words, then moves to CMD. wdat_ready for non-granted requesters is always 0.
// - CMD: mcb_cmd_en = 1 for exactly one cycle when !mcb_cmd_full, driving the latched fields.
//   - For reads, {id, bl} is pushed into the tag FIFO in the same cycle.
//   - CMD then returns to ARB. Back-to-back grants need at least 1 ARB cycle.
// - Read return runs independently of the FSM.
//   - When the tag FIFO is not empty and !mcb_rd_empty: rdat_valid[head.id] = 1 and rdat_data = mcb_rd_data.
//   - mcb_rd_en = rdat_valid & rdat_ready (same-cycle pop, no extra latency).
//   - The remaining count decrements per pop; the tag pops on the last word.
// - Simultaneous tag push and pop in one cycle are both honoured; the tag count is unchanged.
// - Counters wrap modulo 2^6; bl = 63 gives 64 words.
// - calib_done falling has no effect after leaving CALIB.
// CONFIGURATION
// - MCB_ARB_STRICT_PRIO_EN defined: fixed priority, lowest index wins.
// - MCB_ARB_STRICT_PRIO_EN undefined (default): round-robin as above.
// STRUCTURE
// - mcb_arb_pkg.vh: MCB instr localparams, FSM state encodings, tag field widths.
// - Sub-module mcb_arb_tag_fifo: synchronous FIFO, width clog2(NUM_REQ)+6, depth TAG_DEPTH,
//   with full/empty flags.
// TESTING
// - calib_done low 50 cycles with req_valid = 1 -> no req_ready and no mcb_cmd_en until calib_done rises.
// - Req0 WR_AP, bl = 3, addr 0x100, data 1..4 -> 4 mcb_wr_en pulses, then 1 mcb_cmd_en (instr 2, bl 3, addr 0x100).
// - Req0 and req1 both request continuously -> grants alternate 0,1,0,1.
//   - With MCB_ARB_STRICT_PRIO_EN: grants are 0 only.
// - mcb_wr_full held 10 cycles mid-burst -> wdat_ready = 0 and no wr_en; the burst resumes and completes with 64 words.
// - Req1 RD bl 1, then req0 RD bl 0; the model returns 3 words -> 2 words go to rdat_valid[1], then 1 to rdat_valid[0].
// - TAG_DEPTH reads outstanding and no data returned -> the next read is not granted and a pending write is granted; rst mid-WDATA -> no cmd_en.

Source files
------------

// File: rtl/mcb_port_arbiter_pkg.sv
// rtl/mcb_port_arbiter_pkg.sv - MCB instruction codes, FSM states and field widths for the port arbiter
package mcb_port_arbiter_pkg;

    localparam int BL_W    = 6;
    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int MASK_W  = 4;
    localparam int INSTR_W = 3;

    localparam logic [INSTR_W-1:0] INSTR_WR    = 3'd0;
    localparam logic [INSTR_W-1:0] INSTR_RD    = 3'd1;
    localparam logic [INSTR_W-1:0] INSTR_WR_AP = 3'd2;
    localparam logic [INSTR_W-1:0] INSTR_RD_AP = 3'd3;
    localparam logic [INSTR_W-1:0] INSTR_REF   = 3'd4;

    typedef enum logic [1:0] {
        ST_CALIB = 2'd0,
        ST_ARB   = 2'd1,
        ST_WDATA = 2'd2,
        ST_CMD   = 2'd3
    } arb_state_e;

    function automatic logic is_write(input logic [INSTR_W-1:0] instr);
        return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
    endfunction

    function automatic logic is_read(input logic [INSTR_W-1:0] instr);
        return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
    endfunction

endpackage

// File: rtl/mcb_port_arbiter_if.sv
// rtl/mcb_port_arbiter_if.sv - MCB user port (cmd/wr/rd FIFO) bundle between arbiter and MIG wrapper
interface mcb_port_arbiter_if;
    import mcb_port_arbiter_pkg::*;

    logic                cmd_en;
    logic [INSTR_W-1:0]  cmd_instr;
    logic [BL_W-1:0]     cmd_bl;
    logic [ADDR_W-1:0]   cmd_byte_addr;
    logic                cmd_full;
    logic                wr_en;
    logic [MASK_W-1:0]   wr_mask;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_full;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_empty;

    modport master (
        output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
        input  cmd_full, wr_full, rd_data, rd_empty
    );

    modport slave (
        input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en,
        output cmd_full, wr_full, rd_data, rd_empty
    );

endinterface

// File: rtl/mcb_port_arbiter_tag_fifo.sv
// rtl/mcb_port_arbiter_tag_fifo.sv - outstanding-read tag FIFO ({requester id, bl}), simultaneous push/pop allowed
module mcb_port_arbiter_tag_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/mcb_port_arbiter.sv
// rtl/mcb_port_arbiter.sv - shares one MCB user port among NUM_REQ requesters; MCB_ARB_STRICT_PRIO_EN selects fixed priority
module mcb_port_arbiter
    import mcb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        calib_done_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [INSTR_W*NUM_REQ-1:0]  req_instr_i,
    input  logic [BL_W*NUM_REQ-1:0]     req_bl_i,
    input  logic [ADDR_W*NUM_REQ-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0]          wdat_valid_i,
    output logic [NUM_REQ-1:0]          wdat_ready_o,
    input  logic [DATA_W*NUM_REQ-1:0]   wdat_data_i,
    input  logic [MASK_W*NUM_REQ-1:0]   wdat_mask_i,
    output logic [NUM_REQ-1:0]          rdat_valid_o,
    input  logic [NUM_REQ-1:0]          rdat_ready_i,
    output logic [DATA_W-1:0]           rdat_data_o,
    mcb_port_arbiter_if.master          mcb
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_W = ID_W + BL_W;

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d, gnt_q, gnt_d, sel;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [BL_W-1:0]     bl_q, bl_d, wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [MASK_W-1:0]   wr_mask_q, wr_mask_d;
    logic [NUM_REQ-1:0]  elig;
    logic                sel_found;
    logic                tag_full, tag_empty, tag_push, tag_pop, rd_avail, rd_pop;
    logic [TAG_W-1:0]    tag_dout;
    logic [ID_W-1:0]     head_id;
    logic [BL_W-1:0]     head_bl;

    // Reads need a free tag slot; writes and REF never block on the tag FIFO.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] && !(is_read(req_instr_i[INSTR_W*i +: INSTR_W]) && tag_full);
        end
    end

    always_comb begin : p_select
        int idx;
        logic [ID_W-1:0] idx_id;
        idx       = 0;
        idx_id    = '0;
        sel       = '0;
        sel_found = 1'b0;
`ifdef MCB_ARB_STRICT_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_id = ID_W'(i);
            if (elig[idx_id]) begin
                sel       = idx_id;
                sel_found = 1'b1;
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_id = ID_W'(idx);
            if (!sel_found && elig[idx_id]) begin
                sel       = idx_id;
                sel_found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        instr_d      = instr_q;
        bl_d         = bl_q;
        addr_d       = addr_q;
        wcnt_d       = wcnt_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        wr_mask_d    = wr_mask_q;
        req_ready_o  = '0;
        wdat_ready_o = '0;
        mcb.cmd_en   = 1'b0;
        tag_push     = 1'b0;
        case (state_q)
            ST_CALIB: begin
                if (calib_done_i) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (sel_found) begin
                    req_ready_o[sel] = 1'b1;
                    gnt_d   = sel;
                    instr_d = req_instr_i[INSTR_W*sel +: INSTR_W];
                    bl_d    = req_bl_i[BL_W*sel +: BL_W];
                    addr_d  = req_addr_i[ADDR_W*sel +: ADDR_W];
                    rr_d    = (int'(sel) == NUM_REQ - 1) ? '0 : ID_W'(int'(sel) + 1);
                    wcnt_d  = '0;
                    state_d = is_write(instr_d) ? ST_WDATA : ST_CMD;
                end
            end
            ST_WDATA: begin
                wdat_ready_o[gnt_q] = !mcb.wr_full;
                if (wdat_valid_i[gnt_q] && !mcb.wr_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = wdat_data_i[DATA_W*gnt_q +: DATA_W];
                    wr_mask_d = wdat_mask_i[MASK_W*gnt_q +: MASK_W];
                    if (wcnt_q == bl_q) begin
                        wcnt_d  = '0;
                        state_d = ST_CMD;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_CMD: begin
                // Hold the command until the last registered data word has been pushed.
                if (!mcb.cmd_full && !wr_en_q) begin
                    mcb.cmd_en = 1'b1;
                    tag_push   = is_read(instr_q);
                    state_d    = ST_ARB;
                end
            end
            default: state_d = ST_CALIB;
        endcase
    end

    assign mcb.cmd_instr     = instr_q;
    assign mcb.cmd_bl        = bl_q;
    assign mcb.cmd_byte_addr = addr_q;
    assign mcb.wr_en         = wr_en_q;
    assign mcb.wr_data       = wr_data_q;
    assign mcb.wr_mask       = wr_mask_q;

    assign head_id  = tag_dout[TAG_W-1:BL_W];
    assign head_bl  = tag_dout[BL_W-1:0];
    assign rd_avail = !tag_empty && !mcb.rd_empty;
    assign rd_pop   = rd_avail && rdat_ready_i[head_id];
    assign tag_pop  = rd_pop && (rcnt_q == head_bl);
    assign rcnt_d   = rd_pop ? (tag_pop ? '0 : rcnt_q + 1'b1) : rcnt_q;
    assign mcb.rd_en = rd_pop;
    assign rdat_data_o = mcb.rd_data;

    always_comb begin
        rdat_valid_o = '0;
        if (rd_avail) rdat_valid_o[head_id] = 1'b1;
    end

    mcb_port_arbiter_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tag_push),
        .din_i   ({gnt_q, bl_q}),
        .pop_i   (tag_pop),
        .dout_o  (tag_dout),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CALIB;
            rr_q      <= '0;
            gnt_q     <= '0;
            instr_q   <= '0;
            bl_q      <= '0;
            addr_q    <= '0;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            instr_q   <= instr_d;
            bl_q      <= bl_d;
            addr_q    <= addr_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
        end
    end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// tb/tb_mcb_port_arbiter.sv - self-checking bench for mcb_port_arbiter with an MCB port model
module tb_mcb_port_arbiter;

    typedef struct packed { logic [2:0] instr; logic [5:0] bl; logic [29:0] addr; } cmd_t;
    typedef struct packed { logic [3:0] mask; logic [31:0] data; } wr_t;
    typedef struct packed { logic [1:0] id; logic [31:0] data; } rd_t;
    typedef struct { int id; logic [2:0] instr; logic [5:0] bl; logic [29:0] addr; int nwr; int nrd; } vec_t;

    logic        clk = 1'b0;
    logic        rst, calib_done;
    logic [1:0]  req_valid, req_ready_o, wdat_valid, wdat_ready_o, rdat_valid_o, rdat_ready;
    logic [5:0]  req_instr;
    logic [11:0] req_bl;
    logic [59:0] req_addr;
    logic [63:0] wdat_data;
    logic [7:0]  wdat_mask;
    logic [31:0] rdat_data_o;

    logic        cmd_full_r, wr_full_r, rd_hold, rd_has, rand_bg, wgap, auto_ret, rd_pop_pend;
    logic [31:0] rd_head;
    logic [1:0]  acc_pend;
    int          nchk = 0, nfail = 0;

    cmd_t        cmd_log[$], exp_cmd[$];
    wr_t         wr_log[$], exp_wr[$], wq0[$], wq1[$];
    rd_t         rd_log[$], exp_rd[$];
    int          grant_log[$];
    logic [31:0] rd_q[$], ret_pend[$];
    vec_t        tbl[6];

    mcb_port_arbiter_if mcb_if();

    assign mcb_if.cmd_full = cmd_full_r;
    assign mcb_if.wr_full  = wr_full_r;
    assign mcb_if.rd_data  = rd_head;
    assign mcb_if.rd_empty = !rd_has || rd_hold;

    mcb_port_arbiter #(.NUM_REQ(2), .TAG_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .calib_done_i (calib_done),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_instr_i  (req_instr),
        .req_bl_i     (req_bl),
        .req_addr_i   (req_addr),
        .wdat_valid_i (wdat_valid),
        .wdat_ready_o (wdat_ready_o),
        .wdat_data_i  (wdat_data),
        .wdat_mask_i  (wdat_mask),
        .rdat_valid_o (rdat_valid_o),
        .rdat_ready_i (rdat_ready),
        .rdat_data_o  (rdat_data_o),
        .mcb          (mcb_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rfun(input logic [29:0] a, input int k);
        return {2'b00, a} + (32'(k) << 20);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clr_logs();
        cmd_log.delete(); wr_log.delete(); rd_log.delete(); grant_log.delete();
        exp_cmd.delete(); exp_wr.delete(); exp_rd.delete();
    endtask

    // Monitor and MCB model front half: everything is observed mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (req_ready_o[i]) grant_log.push_back(i);
            if (wdat_valid[i] && wdat_ready_o[i]) acc_pend[i] = 1'b1;
        end
        if (mcb_if.cmd_en) begin
            cmd_log.push_back({mcb_if.cmd_instr, mcb_if.cmd_bl, mcb_if.cmd_byte_addr});
            if (auto_ret && (mcb_if.cmd_instr == 3'd1 || mcb_if.cmd_instr == 3'd3))
                for (int k = 0; k <= int'(mcb_if.cmd_bl); k++) ret_pend.push_back(rfun(mcb_if.cmd_byte_addr, k));
        end
        if (mcb_if.wr_en) wr_log.push_back({mcb_if.wr_mask, mcb_if.wr_data});
        if (mcb_if.rd_en) begin
            rd_log.push_back({(rdat_valid_o[1] ? 2'd1 : 2'd0), rdat_data_o});
            rd_pop_pend = 1'b1;
        end
    end

    always @(posedge clk) begin
        logic [31:0] tmp;
        #1;
        if (rd_pop_pend && rd_q.size() > 0) tmp = rd_q.pop_front();
        rd_pop_pend = 1'b0;
        while (ret_pend.size() > 0) rd_q.push_back(ret_pend.pop_front());
        rd_has  = rd_q.size() > 0;
        rd_head = rd_has ? rd_q[0] : 32'h0;
    end

    always @(posedge clk) begin
        wr_t tmp;
        #1;
        if (acc_pend[0] && wq0.size() > 0) tmp = wq0.pop_front();
        if (acc_pend[1] && wq1.size() > 0) tmp = wq1.pop_front();
        acc_pend = 2'b00;
        wdat_valid[0] = (wq0.size() > 0) && !(wgap && $urandom_range(0, 2) == 0);
        wdat_valid[1] = (wq1.size() > 0) && !(wgap && $urandom_range(0, 2) == 0);
        if (wq0.size() > 0) {wdat_mask[3:0], wdat_data[31:0]}  = wq0[0];
        if (wq1.size() > 0) {wdat_mask[7:4], wdat_data[63:32]} = wq1[0];
    end

    always @(posedge clk) begin
        #1;
        if (rand_bg) begin
            cmd_full_r = ($urandom_range(0, 3) == 0);
            wr_full_r  = ($urandom_range(0, 3) == 0);
            rd_hold    = ($urandom_range(0, 2) == 0);
            rdat_ready = 2'($urandom);
        end
    end

    task automatic push_word(input int id, input wr_t w);
        if (id == 0) wq0.push_back(w); else wq1.push_back(w);
    endtask

    task automatic issue(input int id, input logic [2:0] instr, input logic [5:0] bl,
                         input logic [29:0] addr, output bit ok);
        @(posedge clk); #1;
        req_instr[3*id +: 3] = instr;
        req_bl[6*id +: 6]    = bl;
        req_addr[30*id +: 30] = addr;
        req_valid[id]        = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            if (req_ready_o[id]) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_sizes(input string name, input int ncmd, input int nrd, input int nwr, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = (cmd_log.size() >= ncmd) && (rd_log.size() >= nrd) && (wr_log.size() >= nwr);
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        wq0.delete(); wq1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout checks=%0d", nchk);
        $fatal(1);
    end

    initial begin
        bit ok;
        int viol_rdy, viol_wen;
        rst = 1'b1; calib_done = 1'b0; req_valid = '0; req_instr = '0; req_bl = '0; req_addr = '0;
        rdat_ready = 2'b11; cmd_full_r = 1'b0; wr_full_r = 1'b0; rd_hold = 1'b0; rand_bg = 1'b0;
        wgap = 1'b0; auto_ret = 1'b1; rd_pop_pend = 1'b0; acc_pend = '0; rd_has = 1'b0; rd_head = '0;
        wdat_valid = '0; wdat_data = '0; wdat_mask = '0;

        tbl[0] = '{0, 3'd2, 6'd3,  30'h100,  4,  0};
        tbl[1] = '{1, 3'd0, 6'd0,  30'h2000, 1,  0};
        tbl[2] = '{1, 3'd1, 6'd1,  30'h40,   0,  2};
        tbl[3] = '{0, 3'd4, 6'd0,  30'h0,    0,  0};
        tbl[4] = '{0, 3'd3, 6'd63, 30'h80,   0,  64};
        tbl[5] = '{1, 3'd0, 6'd7,  30'h3ff0, 8,  0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_wdat_ready", 64'(wdat_ready_o), 64'd0);
        chk("rst_rdat_valid", 64'(rdat_valid_o), 64'd0);
        chk("rst_cmd_en", 64'(mcb_if.cmd_en), 64'd0);
        chk("rst_wr_en", 64'(mcb_if.wr_en), 64'd0);
        chk("rst_rd_en", 64'(mcb_if.rd_en), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Calibration gate
        req_instr[2:0] = 3'd4; req_valid[0] = 1'b1;
        repeat (50) @(posedge clk);
        chk("calib_no_grant", 64'(grant_log.size()), 64'd0);
        chk("calib_no_cmd", 64'(cmd_log.size()), 64'd0);
        #1 calib_done = 1'b1;
        for (int c = 0; c < 20 && grant_log.size() == 0; c++) @(negedge clk);
        chk("calib_grant", 64'(grant_log.size() > 0), 64'd1);
        @(posedge clk); #1 req_valid = '0;
        wait_sizes("calib_cmd", 1, 0, 0, 50);
        chk("calib_cmd_instr", 64'(cmd_log.size() > 0 ? cmd_log[0].instr : 3'd7), 64'd4);

        // Table-driven single transactions
        for (int v = 0; v < 6; v++) begin
            clr_logs();
            for (int k = 0; k < tbl[v].nwr; k++) push_word(tbl[v].id, {4'(k), 32'(k + 1)});
            issue(tbl[v].id, tbl[v].instr, tbl[v].bl, tbl[v].addr, ok);
            chk("tbl_grant", 64'(ok), 64'd1);
            wait_sizes("tbl_wait", 1, tbl[v].nrd, tbl[v].nwr, 400);
            chk("tbl_ncmd", 64'(cmd_log.size()), 64'd1);
            if (cmd_log.size() > 0)
                chk("tbl_cmd", 64'(cmd_log[0]), 64'({tbl[v].instr, tbl[v].bl, tbl[v].addr}));
            chk("tbl_nwr", 64'(wr_log.size()), 64'(tbl[v].nwr));
            chk("tbl_nrd", 64'(rd_log.size()), 64'(tbl[v].nrd));
            if (tbl[v].nwr > 0 && wr_log.size() == tbl[v].nwr) begin
                chk("tbl_wr_first", 64'(wr_log[0].data), 64'd1);
                chk("tbl_wr_last", 64'(wr_log[tbl[v].nwr-1]), 64'({4'(tbl[v].nwr - 1), 32'(tbl[v].nwr)}));
            end
            if (tbl[v].nrd > 0 && rd_log.size() == tbl[v].nrd)
                chk("tbl_rd_last", 64'(rd_log[tbl[v].nrd-1]),
                    64'({2'(tbl[v].id), rfun(tbl[v].addr, tbl[v].nrd - 1)}));
        end

        // Two continuous requesters
        do_reset();
        clr_logs();
        @(posedge clk); #1;
        req_instr = {3'd4, 3'd4}; req_bl = '0; req_valid = 2'b11;
        for (int c = 0; c < 100 && grant_log.size() < 6; c++) @(negedge clk);
        @(posedge clk); #1 req_valid = '0;
        chk("alt_count", 64'(grant_log.size() >= 6), 64'd1);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
`ifdef MCB_ARB_STRICT_PRIO_EN
            chk("alt_grant", 64'(grant_log[k]), 64'd0);
`else
            chk("alt_grant", 64'(grant_log[k]), 64'(k % 2));
`endif
        end
        repeat (5) @(posedge clk);

        // wr_full stall inside a 64-word burst
        clr_logs();
        for (int k = 0; k < 64; k++) push_word(0, {4'h0, 32'(k)});
        issue(0, 3'd0, 6'd63, 30'h1000, ok);
        chk("stall_grant", 64'(ok), 64'd1);
        for (int c = 0; c < 200 && wr_log.size() < 20; c++) @(negedge clk);
        @(posedge clk); #1 wr_full_r = 1'b1;
        viol_rdy = 0; viol_wen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (wdat_ready_o != 2'b00) viol_rdy++;
            if (c > 0 && mcb_if.wr_en) viol_wen++;
        end
        chk("stall_no_ready", 64'(viol_rdy), 64'd0);
        chk("stall_no_wr_en", 64'(viol_wen), 64'd0);
        @(posedge clk); #1 wr_full_r = 1'b0;
        wait_sizes("stall_wait", 1, 0, 64, 300);
        chk("stall_nwr", 64'(wr_log.size()), 64'd64);
        chk("stall_ncmd", 64'(cmd_log.size()), 64'd1);
        if (cmd_log.size() > 0) chk("stall_cmd_bl", 64'(cmd_log[0].bl), 64'd63);
        if (wr_log.size() == 64) chk("stall_last_word", 64'(wr_log[63].data), 64'd63);

        // Read routing in issue order
        clr_logs();
        issue(1, 3'd1, 6'd1, 30'h500, ok);
        issue(0, 3'd1, 6'd0, 30'h600, ok);
        wait_sizes("route_wait", 2, 3, 0, 200);
        chk("route_nrd", 64'(rd_log.size()), 64'd3);
        if (rd_log.size() == 3) begin
            chk("route_w0", 64'(rd_log[0]), 64'({2'd1, rfun(30'h500, 0)}));
            chk("route_w1", 64'(rd_log[1]), 64'({2'd1, rfun(30'h500, 1)}));
            chk("route_w2", 64'(rd_log[2]), 64'({2'd0, rfun(30'h600, 0)}));
        end

        // Tag FIFO full, then reset during WDATA
        clr_logs();
        auto_ret = 1'b0;
        for (int k = 0; k < 4; k++) issue(0, 3'd1, 6'd0, 30'(k * 16), ok);
        wait_sizes("tag_fill", 4, 0, 0, 50);
        for (int k = 0; k < 3; k++) push_word(1, {4'h0, 32'(k)});
        grant_log.delete();
        @(posedge clk); #1;
        req_instr = {3'd0, 3'd1}; req_bl = {6'd7, 6'd0}; req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready_o[1]) begin
                @(posedge clk); #1 req_valid[1] = 1'b0;
            end
        end
        @(posedge clk); #1 req_valid = '0;
        chk("tagfull_wr_granted", 64'(grant_log.size() == 1 && grant_log[0] == 1), 64'd1);
        wait_sizes("tagfull_partial", 4, 0, 3, 50);
        do_reset();
        repeat (20) @(negedge clk);
        chk("rst_mid_burst_no_cmd", 64'(cmd_log.size()), 64'd4);
        chk("rst_mid_burst_nwr", 64'(wr_log.size()), 64'd3);
        auto_ret = 1'b1;

        // Randomised traffic against the issue-order model
        clr_logs();
        rand_bg = 1'b1; wgap = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int id;
            logic [2:0] instr;
            logic [5:0] bl;
            logic [29:0] addr;
            id    = $urandom_range(0, 1);
            instr = 3'($urandom_range(0, 4));
            bl    = 6'($urandom_range(0, 15));
            addr  = 30'($urandom);
            exp_cmd.push_back({instr, bl, addr});
            if (instr == 3'd0 || instr == 3'd2)
                for (int k = 0; k <= int'(bl); k++) begin
                    wr_t w;
                    w = {4'($urandom), 32'($urandom)};
                    push_word(id, w);
                    exp_wr.push_back(w);
                end
            if (instr == 3'd1 || instr == 3'd3)
                for (int k = 0; k <= int'(bl); k++) exp_rd.push_back({2'(id), rfun(addr, k)});
            issue(id, instr, bl, addr, ok);
            chk("rand_grant", 64'(ok), 64'd1);
        end
        wait_sizes("rand_wait", exp_cmd.size(), exp_rd.size(), exp_wr.size(), 6000);
        rand_bg = 1'b0; wgap = 1'b0;
        chk("rand_ncmd", 64'(cmd_log.size()), 64'(exp_cmd.size()));
        chk("rand_nwr", 64'(wr_log.size()), 64'(exp_wr.size()));
        chk("rand_nrd", 64'(rd_log.size()), 64'(exp_rd.size()));
        for (int k = 0; k < exp_cmd.size() && k < cmd_log.size(); k++) chk("rand_cmd", 64'(cmd_log[k]), 64'(exp_cmd[k]));
        for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++) chk("rand_wr", 64'(wr_log[k]), 64'(exp_wr[k]));
        for (int k = 0; k < exp_rd.size() && k < rd_log.size(); k++) chk("rand_rd", 64'(rd_log[k]), 64'(exp_rd[k]));

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
